// File: rtl/quad_encoder_velocity.sv
// Quadrature encoder front end: synchroniser, per-channel glitch filter, x4 decoder,
// windowed velocity measurement and a small Avalon-MM register block.
module quad_encoder_velocity #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_LEN    = 4,
    parameter int WINDOW_CYCLES = 500000
) (
    input  logic        clk_clk,
    input  logic        rst_reset,
    input  logic [1:0]  encoded_in,
    input  logic [1:0]  avalon_slave_address,
    input  logic        avalon_slave_read,
    output logic [31:0] avalon_slave_readdata,
    input  logic        avalon_slave_write,
    input  logic [31:0] avalon_slave_writedata,
    output logic [31:0] position,
    output logic [31:0] velocity,
    output logic        velocity_valid
);

    localparam int FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int WCW = $clog2(WINDOW_CYCLES);
    localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
    localparam logic [WCW-1:0] WIN_LAST = WCW'(WINDOW_CYCLES - 1);

    logic [2*SYNC_STAGES-1:0] sync_q;
    logic [1:0]               sync_ab;
    logic [1:0]               filt_ab;

    always_ff @(posedge clk_clk) begin
        if (rst_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[2*SYNC_STAGES-3:0], encoded_in};
        end
    end

    assign sync_ab = sync_q[2*SYNC_STAGES-1 -: 2];

    // A level is accepted only after it has differed from the filtered value for FILTER_LEN cycles.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic [FCW-1:0] cnt_q;
            logic           bit_q;

            always_ff @(posedge clk_clk) begin
                if (rst_reset) begin
                    cnt_q <= '0;
                    bit_q <= 1'b0;
                end else if (sync_ab[gi] != bit_q) begin
                    if (cnt_q == FILT_MAX) begin
                        bit_q <= sync_ab[gi];
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end

            assign filt_ab[gi] = bit_q;
        end
    endgenerate

    // Map the Gray sequence 00,01,11,10 onto 0..3 so a step is a modulo-4 difference.
    function automatic logic [1:0] gray_idx(input logic [1:0] s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    logic [1:0]     prev_q;
    logic           init_q;
    logic [1:0]     delta;
    logic           changed;
    logic           step_up;
    logic           step_dn;
    logic           illegal;
    logic [31:0]    pos_q;
    logic [31:0]    pos_d;
    logic [31:0]    snap_q;
    logic [31:0]    vel_q;
    logic           valid_q;
    logic           new_sample_q;
    logic           err_q;
    logic [WCW-1:0] win_cnt_q;
    logic           terminal;
    logic           wr_pos;
    logic           wr_err;
    logic           rd_vel;

    always_comb begin
        delta   = gray_idx(filt_ab) - gray_idx(prev_q);
        changed = (filt_ab != prev_q);
        step_up = changed && !init_q && (delta == 2'd1);
        step_dn = changed && !init_q && (delta == 2'd3);
        illegal = changed && !init_q && (delta == 2'd2);
    end

    assign wr_pos   = avalon_slave_write && (avalon_slave_address == 2'd0);
    assign wr_err   = avalon_slave_write && (avalon_slave_address == 2'd2) && avalon_slave_writedata[0];
    assign rd_vel   = avalon_slave_read && (avalon_slave_address == 2'd1);
    assign terminal = (win_cnt_q == WIN_LAST);

    always_comb begin
        pos_d = pos_q;
        if (wr_pos) begin
            pos_d = avalon_slave_writedata;
        end else if (step_up) begin
            pos_d = pos_q + 32'd1;
        end else if (step_dn) begin
            pos_d = pos_q - 32'd1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (rst_reset) begin
            prev_q       <= 2'b00;
            init_q       <= 1'b1;
            pos_q        <= '0;
            snap_q       <= '0;
            vel_q        <= '0;
            valid_q      <= 1'b0;
            new_sample_q <= 1'b0;
            err_q        <= 1'b0;
            win_cnt_q    <= '0;
        end else begin
            prev_q  <= filt_ab;
            pos_q   <= pos_d;
            valid_q <= terminal;
            if (changed) begin
                init_q <= 1'b0;
            end
            win_cnt_q <= terminal ? '0 : win_cnt_q + 1'b1;
            // Velocity is taken from the position before this cycle's step or preset.
            if (terminal) begin
                vel_q  <= pos_q - snap_q;
                snap_q <= pos_q;
            end
            if (wr_pos) begin
                snap_q <= avalon_slave_writedata;
            end
            if (terminal) begin
                new_sample_q <= 1'b1;
            end else if (rd_vel) begin
                new_sample_q <= 1'b0;
            end
            if (illegal) begin
                err_q <= 1'b1;
            end else if (wr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    always_comb begin
        avalon_slave_readdata = '0;
        case (avalon_slave_address)
            2'd0:    avalon_slave_readdata = pos_q;
            2'd1:    avalon_slave_readdata = vel_q;
            2'd2:    avalon_slave_readdata = {30'b0, new_sample_q, err_q};
            default: avalon_slave_readdata = 32'(WINDOW_CYCLES);
        endcase
    end

    assign position       = pos_q;
    assign velocity       = vel_q;
    assign velocity_valid = valid_q;

endmodule
